nap_read_arbiter: RTL and testbench

- Shares the read channels (AR/R) of one AXI master NAP between NUM_REQ independent requesters in the fabric.
- AR requests are arbitrated round-robin and registered onto the NAP AR channel. The requester index is encoded in the upper ARID bits.
- R beats are routed back to the owning requester by decoding the RID tag.
- Per-requester outstanding-burst counters throttle requesters and provide flow-control visibility.

---
 rtl/nap_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/nap_read_arbiter.sv | 100 ++++++++++
 tb/tb_nap_read_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nap_arb_pkg.sv
// nap_arb_pkg: AXI encodings and the AR record shared by the NAP arbiters
package nap_arb_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam int AR_ADDR_MAX = 64;
  localparam int AR_ID_MAX = 16;
  typedef struct packed {
    logic [AR_ADDR_MAX-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [AR_ID_MAX-1:0] id;
  } ar_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, priority starts at ptr and moves past the winner on advance
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr;
  logic found;
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    grant = found ? N'(1) << idx : '0;
  end
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (advance && found) ptr <= idx == IW'(N - 1) ? '0 : idx + 1'b1;
endmodule

// File: rtl/nap_read_arbiter.sv
// nap_read_arbiter: shares one NAP AR/R channel pair between NUM_REQ requesters via RID tagging
module nap_read_arbiter
  import nap_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH = 8,
  parameter int TAG_WIDTH = $clog2(NUM_REQ),
  parameter int MAX_OUTST = 8
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,
  input  logic [NUM_REQ-1:0]                     i_req_arvalid,
  output logic [NUM_REQ-1:0]                     o_req_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]          i_req_araddr,
  input  logic [NUM_REQ*8-1:0]                   i_req_arlen,
  input  logic [NUM_REQ*3-1:0]                   i_req_arsize,
  input  logic [NUM_REQ*(ID_WIDTH-TAG_WIDTH)-1:0] i_req_arid,
  output logic [NUM_REQ-1:0]                     o_req_rvalid,
  input  logic [NUM_REQ-1:0]                     i_req_rready,
  output logic [DATA_WIDTH-1:0]                  o_req_rdata,
  output logic [1:0]                             o_req_rresp,
  output logic                                   o_req_rlast,
  output logic [ID_WIDTH-TAG_WIDTH-1:0]          o_req_rid,
  output logic                                   nap_arvalid,
  input  logic                                   nap_arready,
  output logic [ADDR_WIDTH-1:0]                  nap_araddr,
  output logic [7:0]                             nap_arlen,
  output logic [2:0]                             nap_arsize,
  output logic [1:0]                             nap_arburst,
  output logic [ID_WIDTH-1:0]                    nap_arid,
  output logic [3:0]                             nap_arqos,
  output logic                                   nap_arlock,
  input  logic                                   nap_rvalid,
  output logic                                   nap_rready,
  input  logic [DATA_WIDTH-1:0]                  nap_rdata,
  input  logic [1:0]                             nap_rresp,
  input  logic [ID_WIDTH-1:0]                    nap_rid,
  input  logic                                   nap_rlast,
  output logic [NUM_REQ*4-1:0]                   o_outstanding,
  output logic                                   o_tag_error
);
  localparam int LW = ID_WIDTH - TAG_WIDTH;
  logic [3:0] cnt [NUM_REQ];
  logic [NUM_REQ-1:0] elig, grant;
  logic [TAG_WIDTH-1:0] win, tag;
  logic can_accept, accept, tag_ok, r_last_hs;
  ar_t ar_d, ar_q;
  logic unused_ar;
  always_comb
    for (int k = 0; k < NUM_REQ; k++) elig[k] = i_req_arvalid[k] && int'(cnt[k]) < MAX_OUTST;
  assign can_accept = !i_reset && (!nap_arvalid || nap_arready);
  rr_arbiter #(.N(NUM_REQ), .IW(TAG_WIDTH)) u_rr (
    .clk(i_clk), .rst(i_reset), .req(elig), .advance(can_accept), .grant(grant), .idx(win)
  );
  assign o_req_arready = can_accept ? grant : '0;
  assign accept = |o_req_arready;
  always_comb begin
    ar_d = '0;
    ar_d.addr[ADDR_WIDTH-1:0] = i_req_araddr[win*ADDR_WIDTH +: ADDR_WIDTH];
    ar_d.len = i_req_arlen[win*8 +: 8];
    ar_d.size = i_req_arsize[win*3 +: 3];
    ar_d.id[ID_WIDTH-1:0] = {win, i_req_arid[win*LW +: LW]};
  end
  always_ff @(posedge i_clk)
    if (i_reset) nap_arvalid <= 1'b0;
    else if (accept) nap_arvalid <= 1'b1;
    else if (nap_arready) nap_arvalid <= 1'b0;
  always_ff @(posedge i_clk)
    if (accept) ar_q <= ar_d;
  assign nap_araddr = ar_q.addr[ADDR_WIDTH-1:0];
  assign nap_arlen = ar_q.len;
  assign nap_arsize = ar_q.size;
  assign nap_arid = ar_q.id[ID_WIDTH-1:0];
  assign nap_arburst = AXI_BURST_INCR;
  assign nap_arqos = 4'd0;
  assign nap_arlock = 1'b0;
  assign unused_ar = ^ar_q;
  // Beats carrying an unknown tag are swallowed so the NAP never stalls on them
  assign tag = nap_rid[ID_WIDTH-1 -: TAG_WIDTH];
  assign tag_ok = int'(tag) < NUM_REQ;
  assign o_req_rvalid = nap_rvalid && tag_ok ? NUM_REQ'(1) << tag : '0;
  assign nap_rready = tag_ok ? i_req_rready[tag] : 1'b1;
  assign o_req_rdata = nap_rdata;
  assign o_req_rresp = nap_rresp;
  assign o_req_rlast = nap_rlast;
  assign o_req_rid = nap_rid[LW-1:0];
  assign r_last_hs = nap_rvalid && nap_rready && nap_rlast && tag_ok;
  always_ff @(posedge i_clk)
    if (i_reset) o_tag_error <= 1'b0;
    else if (nap_rvalid && !tag_ok) o_tag_error <= 1'b1;
  always_ff @(posedge i_clk)
    for (int k = 0; k < NUM_REQ; k++)
      if (i_reset) cnt[k] <= '0;
      else cnt[k] <= cnt[k] + {3'b0, o_req_arready[k]} - {3'b0, r_last_hs && int'(tag) == k};
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_out
    assign o_outstanding[g*4 +: 4] = cnt[g];
  end
endmodule

// File: tb/tb_nap_read_arbiter.sv
// tb_nap_read_arbiter: scoreboarded AR ordering plus table-driven R routing checks
module tb_nap_read_arbiter;
  localparam int N = 4, AW = 42, DW = 256, LW = 6;
  logic clk = 1'b0, rst;
  always #5 clk = ~clk;
  logic [N-1:0] req_arvalid, req_arready, req_rvalid, req_rready;
  logic [N*AW-1:0] req_araddr;
  logic [N*8-1:0] req_arlen;
  logic [N*3-1:0] req_arsize;
  logic [N*LW-1:0] req_arid;
  logic [DW-1:0] req_rdata, nap_rdata;
  logic [1:0] req_rresp, nap_rresp, nap_arburst;
  logic req_rlast, nap_rlast, nap_arvalid, nap_arready, nap_arlock, nap_rvalid, nap_rready, tag_err;
  logic [LW-1:0] req_rid;
  logic [AW-1:0] nap_araddr;
  logic [7:0] nap_arlen, nap_arid, nap_rid;
  logic [2:0] nap_arsize;
  logic [3:0] nap_arqos;
  logic [15:0] outst;
  logic [2:0] rvalid3, rready3, arready3, nap_arsize3;
  logic [DW-1:0] rdata3;
  logic [1:0] rresp3, nap_arburst3;
  logic rlast3, nap_arvalid3, nap_arlock3, nap_rvalid3, nap_rready3, tag_err3;
  logic [LW-1:0] rid3;
  logic [AW-1:0] nap_araddr3;
  logic [7:0] nap_arlen3, nap_arid3, nap_rid3;
  logic [3:0] nap_arqos3;
  logic [11:0] outst3;

  nap_read_arbiter dut (
    .i_clk(clk), .i_reset(rst), .i_req_arvalid(req_arvalid), .o_req_arready(req_arready),
    .i_req_araddr(req_araddr), .i_req_arlen(req_arlen), .i_req_arsize(req_arsize), .i_req_arid(req_arid),
    .o_req_rvalid(req_rvalid), .i_req_rready(req_rready), .o_req_rdata(req_rdata), .o_req_rresp(req_rresp),
    .o_req_rlast(req_rlast), .o_req_rid(req_rid), .nap_arvalid(nap_arvalid), .nap_arready(nap_arready),
    .nap_araddr(nap_araddr), .nap_arlen(nap_arlen), .nap_arsize(nap_arsize), .nap_arburst(nap_arburst),
    .nap_arid(nap_arid), .nap_arqos(nap_arqos), .nap_arlock(nap_arlock), .nap_rvalid(nap_rvalid),
    .nap_rready(nap_rready), .nap_rdata(nap_rdata), .nap_rresp(nap_rresp), .nap_rid(nap_rid),
    .nap_rlast(nap_rlast), .o_outstanding(outst), .o_tag_error(tag_err)
  );

  nap_read_arbiter #(.NUM_REQ(3)) dut3 (
    .i_clk(clk), .i_reset(rst), .i_req_arvalid(3'b000), .o_req_arready(arready3),
    .i_req_araddr('0), .i_req_arlen('0), .i_req_arsize('0), .i_req_arid('0),
    .o_req_rvalid(rvalid3), .i_req_rready(rready3), .o_req_rdata(rdata3), .o_req_rresp(rresp3),
    .o_req_rlast(rlast3), .o_req_rid(rid3), .nap_arvalid(nap_arvalid3), .nap_arready(1'b1),
    .nap_araddr(nap_araddr3), .nap_arlen(nap_arlen3), .nap_arsize(nap_arsize3), .nap_arburst(nap_arburst3),
    .nap_arid(nap_arid3), .nap_arqos(nap_arqos3), .nap_arlock(nap_arlock3), .nap_rvalid(nap_rvalid3),
    .nap_rready(nap_rready3), .nap_rdata(nap_rdata), .nap_rresp(nap_rresp), .nap_rid(nap_rid3),
    .nap_rlast(1'b0), .o_outstanding(outst3), .o_tag_error(tag_err3)
  );

  int n_vec = 0, n_miss = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0] id;
    logic [AW-1:0] addr;
    logic [7:0] len;
  } ar_exp_t;
  ar_exp_t sb[$];
  ar_exp_t e_mon;
  task automatic push_ar(input int w);
    ar_exp_t e;
    e.id = {2'(w), req_arid[w*LW +: LW]};
    e.addr = req_araddr[w*AW +: AW];
    e.len = req_arlen[w*8 +: 8];
    sb.push_back(e);
  endtask

  always @(negedge clk)
    if (!rst && nap_arvalid && nap_arready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL ar_unexpected: got arid %0h with empty scoreboard", nap_arid);
      end else begin
        e_mon = sb.pop_front();
        chk("ar_id", 64'(nap_arid), 64'(e_mon.id));
        chk("ar_addr", 64'(nap_araddr), 64'(e_mon.addr));
        chk("ar_len", 64'(nap_arlen), 64'(e_mon.len));
        chk("ar_burst", 64'(nap_arburst), 64'd1);
      end
    end

  typedef struct {
    logic [1:0] tag;
    logic rv;
    logic [3:0] rr;
    logic [3:0] exp_rv;
    logic exp_rdy;
  } rvec_t;
  rvec_t tv[8];

  task automatic do_reset();
    req_arvalid = '0;
    nap_rvalid = 1'b0;
    nap_rvalid3 = 1'b0;
    nap_rlast = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_arvalid = '1;
    req_rready = '1;
    rready3 = '0;
    nap_arready = 1'b1;
    nap_rvalid = 1'b0;
    nap_rvalid3 = 1'b0;
    nap_rlast = 1'b0;
    nap_rid = '0;
    nap_rid3 = '0;
    nap_rdata = '0;
    nap_rresp = 2'b00;
    for (int k = 0; k < N; k++) begin
      req_araddr[k*AW +: AW] = AW'(42'h1000 + k * 'h100);
      req_arlen[k*8 +: 8] = 8'(3 + k);
      req_arsize[k*3 +: 3] = 3'd5;
      req_arid[k*LW +: LW] = LW'(6'h10 + k);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_nap_arvalid", 64'(nap_arvalid), 0);
    chk("rst_arready", 64'(req_arready), 0);
    chk("rst_tag_err", 64'(tag_err), 0);
    chk("rst_outst", 64'(outst), 0);
    chk("rst_tag_err3", 64'(tag_err3), 0);
    req_arvalid = '0;
    rst = 1'b0;
    // single requester, one 4-beat burst
    req_arvalid = 4'b0001;
    #1;
    chk("t1_arready", 64'(req_arready), 64'b0001);
    push_ar(0);
    @(posedge clk); #1;
    req_arvalid = '0;
    chk("t1_nap_arvalid", 64'(nap_arvalid), 1);
    chk("t1_arid_tag", 64'(nap_arid[7:6]), 0);
    chk("t1_outst_1", 64'(outst[3:0]), 1);
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) begin
      nap_rvalid = 1'b1;
      nap_rid = {2'd0, 6'h10};
      nap_rlast = (b == 3);
      nap_rdata = DW'(b + 'hA0);
      #1;
      chk("t1_rvalid", 64'(req_rvalid), 64'b0001);
      chk("t1_rdata", 64'(req_rdata[63:0]), 64'(b + 'hA0));
      chk("t1_outst_mid", 64'(outst[3:0]), 1);
      @(posedge clk); #1;
    end
    nap_rvalid = 1'b0;
    nap_rlast = 1'b0;
    chk("t1_outst_0", 64'(outst[3:0]), 0);
    // all requesters valid, one AR per cycle in round-robin order
    do_reset();
    req_arvalid = '1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t2_grant", 64'(req_arready), 64'(1 << (i % 4)));
      push_ar(i % 4);
      @(posedge clk); #1;
    end
    req_arvalid = '0;
    @(posedge clk); #1;
    chk("t2_outst", 64'(outst), 64'h2222);
    // NAP back-pressure holds the AR register
    do_reset();
    nap_arready = 1'b0;
    req_arvalid = 4'b0100;
    #1;
    chk("t3_first", 64'(req_arready), 64'b0100);
    push_ar(2);
    @(posedge clk); #1;
    req_arvalid = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_hold_valid", 64'(nap_arvalid), 1);
      chk("t3_hold_addr", 64'(nap_araddr), 64'h1200);
      chk("t3_no_ready", 64'(req_arready), 0);
      @(posedge clk); #1;
    end
    nap_arready = 1'b1;
    #1;
    chk("t3_drain_grant", 64'(req_arready), 64'b1000);
    push_ar(3);
    @(posedge clk); #1;
    req_arvalid = '0;
    @(posedge clk); #1;
    // outstanding limit on requester 1
    do_reset();
    req_arvalid = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t4_accept", 64'(req_arready), 64'b0010);
      push_ar(1);
      @(posedge clk); #1;
    end
    #1;
    chk("t4_full_ready", 64'(req_arready), 0);
    chk("t4_full_cnt", 64'(outst[7:4]), 8);
    nap_rvalid = 1'b1;
    nap_rid = {2'd1, 6'h3};
    nap_rlast = 1'b1;
    #1;
    chk("t4_still_blocked", 64'(req_arready), 0);
    chk("t4_rvalid", 64'(req_rvalid), 64'b0010);
    @(posedge clk); #1;
    nap_rvalid = 1'b0;
    nap_rlast = 1'b0;
    #1;
    chk("t4_cnt_after_r", 64'(outst[7:4]), 7);
    chk("t4_ninth", 64'(req_arready), 64'b0010);
    push_ar(1);
    @(posedge clk); #1;
    req_arvalid = '0;
    chk("t4_cnt_refill", 64'(outst[7:4]), 8);
    @(posedge clk); #1;
    // R routing table
    tv[0] = '{2'd1, 1'b1, 4'b1101, 4'b0010, 1'b0};
    tv[1] = '{2'd1, 1'b1, 4'b0010, 4'b0010, 1'b1};
    tv[2] = '{2'd0, 1'b1, 4'b1110, 4'b0001, 1'b0};
    tv[3] = '{2'd0, 1'b1, 4'b0001, 4'b0001, 1'b1};
    tv[4] = '{2'd3, 1'b1, 4'b1000, 4'b1000, 1'b1};
    tv[5] = '{2'd2, 1'b1, 4'b1011, 4'b0100, 1'b0};
    tv[6] = '{2'd2, 1'b0, 4'b0100, 4'b0000, 1'b1};
    tv[7] = '{2'd3, 1'b0, 4'b0111, 4'b0000, 1'b0};
    for (int i = 0; i < 8; i++) begin
      nap_rvalid = tv[i].rv;
      nap_rid = {tv[i].tag, 6'h2A};
      req_rready = tv[i].rr;
      #1;
      chk("tv_rvalid", 64'(req_rvalid), 64'(tv[i].exp_rv));
      chk("tv_nap_rready", 64'(nap_rready), 64'(tv[i].exp_rdy));
      chk("tv_rid", 64'(req_rid), 64'h2A);
    end
    nap_rvalid = 1'b0;
    req_rready = '1;
    // invalid tag on a 3-requester instance
    do_reset();
    nap_rvalid3 = 1'b1;
    nap_rid3 = {2'd3, 6'h05};
    rready3 = 3'b000;
    #1;
    chk("t6_drop_ready", 64'(nap_rready3), 1);
    chk("t6_no_rvalid", 64'(rvalid3), 0);
    @(posedge clk); #1;
    chk("t6_tag_err_set", 64'(tag_err3), 1);
    nap_rvalid3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_tag_err_sticky", 64'(tag_err3), 1);
    chk("t6_main_tag_err", 64'(tag_err), 0);
    nap_rvalid3 = 1'b1;
    nap_rid3 = {2'd2, 6'h05};
    rready3 = 3'b100;
    #1;
    chk("t6_valid_tag_rv", 64'(rvalid3), 64'b100);
    chk("t6_valid_tag_rdy", 64'(nap_rready3), 1);
    do_reset();
    chk("t6_tag_err_clear", 64'(tag_err3), 0);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
